// File: rtl/sbus_mem_responder.sv
// Single-port memory responder for the MBOX request bus. It checks each request,
// waits a programmable number of cycles, acknowledges, and moves one quadword.
module sbus_mem_responder #(
  parameter int AW        = 16,
  parameter int ACK_DELAY = 2
) (
  input  logic          clk,
  input  logic          CROBAR,
  input  logic          START,
  input  logic          RD_RQ,
  input  logic          WR_RQ,
  input  logic [0:3]    RQ,
  input  logic [14:35]  ADR,
  input  logic          ADR_PAR,
  input  logic [35:0]   D_IN,
  output logic          ACKN,
  output logic          DATA_VALID,
  output logic [1:0]    WORD,
  output logic [35:0]   D_OUT,
  output logic          BUSY,
  output logic          PAR_ERR,
  output logic          NXM,
  output logic          RQ_ERR
);

  localparam int unsigned BLK_LIMIT = 2 ** (AW - 2);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, XFER} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      cnt_reg, cnt_next;
  logic            rd_reg, rd_next;
  logic            wr_reg, wr_next;
  logic [0:3]      rq_reg, rq_next;
  logic [AW-3:0]   blk_reg, blk_next;
  logic [1:0]      start_word_reg, start_word_next;
  logic            par_err_reg, par_err_next;
  logic            nxm_reg, nxm_next;
  logic            rq_err_reg, rq_err_next;

  logic [35:0]     mem [0:(2**AW)-1];
  logic [35:0]     rd_data_reg;

  logic [19:0]     adr_blk_in;
  logic            par_ok;
  logic            nxm_hit;
  logic [1:0]      word_cur;
  logic [1:0]      rd_word;
  logic            xfer_active;
  logic            word_valid;
  logic            wr_en;

  assign adr_blk_in  = ADR[14:33];
  assign par_ok      = ADR_PAR ^ (^adr_blk_in);
  assign nxm_hit     = 32'(adr_blk_in) >= BLK_LIMIT;

  assign word_cur    = start_word_reg + cnt_reg[1:0];
  assign xfer_active = (state_reg == XFER);
  assign word_valid  = xfer_active && rq_reg[word_cur];
  assign wr_en       = word_valid && wr_reg;

  // The RAM read is registered, so fetch one word ahead: the first word while in ACK,
  // then the following word during each transfer cycle.
  assign rd_word     = xfer_active ? (word_cur + 2'd1) : start_word_reg;

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    rd_next         = rd_reg;
    wr_next         = wr_reg;
    rq_next         = rq_reg;
    blk_next        = blk_reg;
    start_word_next = start_word_reg;
    par_err_next    = par_err_reg;
    nxm_next        = nxm_reg;
    rq_err_next     = rq_err_reg;

    case (state_reg)
      IDLE: begin
        if (START) begin
          rd_next         = RD_RQ;
          wr_next         = WR_RQ;
          rq_next         = RQ;
          blk_next        = adr_blk_in[AW-3:0];
          start_word_next = ADR[34:35];
          par_err_next    = 1'b0;
          nxm_next        = 1'b0;
          rq_err_next     = 1'b0;
          if (!par_ok) begin
            par_err_next = 1'b1;
          end else if (nxm_hit) begin
            nxm_next = 1'b1;
          end else if (RD_RQ == WR_RQ) begin
            rq_err_next = 1'b1;
          end else if (ACK_DELAY == 0) begin
            state_next = ACK;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(ACK_DELAY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = ACK;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ACK: begin
        cnt_next   = 4'd0;
        state_next = (rq_reg == 4'b0000) ? IDLE : XFER;
      end
      XFER: begin
        if (cnt_reg[1:0] == 2'd3) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (CROBAR) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      rd_reg         <= 1'b0;
      wr_reg         <= 1'b0;
      rq_reg         <= 4'b0000;
      blk_reg        <= '0;
      start_word_reg <= 2'd0;
      par_err_reg    <= 1'b0;
      nxm_reg        <= 1'b0;
      rq_err_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      rd_reg         <= rd_next;
      wr_reg         <= wr_next;
      rq_reg         <= rq_next;
      blk_reg        <= blk_next;
      start_word_reg <= start_word_next;
      par_err_reg    <= par_err_next;
      nxm_reg        <= nxm_next;
      rq_err_reg     <= rq_err_next;
    end
  end

  // Storage has no reset. A word whose DATA_VALID cycle coincides with a reset edge
  // still lands, since the bus already presented it; nothing after that edge writes.
  always_ff @(posedge clk) begin
    rd_data_reg <= mem[{blk_reg, rd_word}];
    if (wr_en) begin
      mem[{blk_reg, word_cur}] <= D_IN;
    end
  end

  assign ACKN       = (state_reg == ACK);
  assign BUSY       = (state_reg != IDLE);
  assign DATA_VALID = word_valid;
  assign WORD       = xfer_active ? word_cur : 2'd0;
  assign D_OUT      = (word_valid && rd_reg) ? rd_data_reg : 36'd0;
  assign PAR_ERR    = par_err_reg;
  assign NXM        = nxm_reg;
  assign RQ_ERR     = rq_err_reg;

endmodule
